// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back controller for the 32x32 integer register file.
//   Three result sources (ALU, LSU, MDU) compete for the single write port.
//   Fixed priority LSU > MDU > ALU, with a starvation override: a source
//   refused STARVE_MAX cycles in a row is promoted above all others
//   (promoted order ALU > MDU > LSU). The winner is registered onto WR/WD/WE.
//   A pending-write scoreboard (busy) feeds RAW/WAW hazard checks in decode.
// Ports:
//   CLK, RST_N                  clock, async active-low reset
//   issue_valid/rd/ready        decode issue of a register-writing instruction
//   flush                       synchronous clear of the scoreboard
//   {alu,lsu,mdu}_valid/rd/wd   result requests; *_ready = grant (combinational)
//   rs1, rs2 / rs1_busy, rs2_busy  hazard query (combinational)
//   WR, WD, WE                  registered register-file write port
`timescale 1ns/1ps

module rf_wb_wait_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic ready,
    output logic promoted
);
    logic [3:0] cnt;

    // Counts consecutive refused cycles; any grant or idle cycle restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (valid && !ready) begin
            if (cnt != 4'(STARVE_MAX))
                cnt <= cnt + 4'd1;
        end else
            cnt <= '0;
    end

    assign promoted = valid && (cnt == 4'(STARVE_MAX));
endmodule

module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            flush,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_wd,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_wd,
    output logic            lsu_ready,
    input  logic            mdu_valid,
    input  logic [AW-1:0]   mdu_rd,
    input  logic [XLEN-1:0] mdu_wd,
    output logic            mdu_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW-1:0]   WR,
    output logic [XLEN-1:0] WD,
    output logic            WE
);
    localparam int ALU = 0;
    localparam int MDU = 1;
    localparam int LSU = 2;
    localparam int NREG = 1 << AW;

    logic [2:0]           req_valid;
    logic [2:0][AW-1:0]   req_rd;
    logic [2:0][XLEN-1:0] req_wd;
    logic [2:0]           gnt;
    logic [2:0]           prom;
    logic [AW-1:0]        sel_rd;
    logic [XLEN-1:0]      sel_wd;
    logic [NREG-1:0]      busy, busy_nxt;

    assign req_valid = {lsu_valid, mdu_valid, alu_valid};
    assign req_rd    = {lsu_rd,    mdu_rd,    alu_rd};
    assign req_wd    = {lsu_wd,    mdu_wd,    alu_wd};

    rf_wb_wait_ctr #(.STARVE_MAX(STARVE_MAX)) u_wait [2:0] (
        .clk      (CLK),
        .rst_n    (RST_N),
        .valid    (req_valid),
        .ready    (gnt),
        .promoted (prom)
    );

    // Promoted sources pre-empt everything; among them ALU > MDU > LSU,
    // which is the reverse of the normal order so the usual loser goes first.
    always_comb begin
        gnt = '0;
        if (|prom) begin
            if (prom[ALU])      gnt[ALU] = 1'b1;
            else if (prom[MDU]) gnt[MDU] = 1'b1;
            else                gnt[LSU] = 1'b1;
        end else if (req_valid[LSU]) gnt[LSU] = 1'b1;
        else if (req_valid[MDU])     gnt[MDU] = 1'b1;
        else if (req_valid[ALU])     gnt[ALU] = 1'b1;
    end

    assign alu_ready = gnt[ALU];
    assign mdu_ready = gnt[MDU];
    assign lsu_ready = gnt[LSU];

    always_comb begin
        sel_rd = '0;
        sel_wd = '0;
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                sel_rd = req_rd[i];
                sel_wd = req_wd[i];
            end
        end
    end

    // A grant to x0 is consumed but never reaches the register file;
    // WR/WD keep their last real write in that case.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WE <= 1'b0;
            WR <= '0;
            WD <= '0;
        end else if (|gnt && sel_rd != '0) begin
            WE <= 1'b1;
            WR <= sel_rd;
            WD <= sel_wd;
        end else
            WE <= 1'b0;
    end

    assign issue_ready = (issue_rd == '0) || !busy[issue_rd];

    // Clear on commit first, then set on issue so a same-index set wins.
    always_comb begin
        busy_nxt = busy;
        if (WE)
            busy_nxt[WR] = 1'b0;
        if (issue_valid && issue_ready && issue_rd != '0)
            busy_nxt[issue_rd] = 1'b1;
        if (flush)
            busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: self-checking bench for rf_wb_arbiter. Directed scenarios
// followed by randomized traffic, all compared against a cycle-level
// behavioural model of the write-back rules kept in this file.
`timescale 1ns/1ps

module tb_rf_wb_arbiter;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int SM   = 4;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic            issue_valid, issue_ready, flush;
    logic [AW-1:0]   issue_rd, rs1, rs2;
    logic            alu_valid, lsu_valid, mdu_valid;
    logic            alu_ready, lsu_ready, mdu_ready;
    logic [AW-1:0]   alu_rd, lsu_rd, mdu_rd;
    logic [XLEN-1:0] alu_wd, lsu_wd, mdu_wd;
    logic            rs1_busy, rs2_busy, WE;
    logic [AW-1:0]   WR;
    logic [XLEN-1:0] WD;

    // requester index: 0 = ALU, 1 = LSU, 2 = MDU
    logic            req_v  [3];
    logic [AW-1:0]   req_rd [3];
    logic [XLEN-1:0] req_wd [3];

    assign alu_valid = req_v[0];  assign alu_rd = req_rd[0];  assign alu_wd = req_wd[0];
    assign lsu_valid = req_v[1];  assign lsu_rd = req_rd[1];  assign lsu_wd = req_wd[1];
    assign mdu_valid = req_v[2];  assign mdu_rd = req_rd[2];  assign mdu_wd = req_wd[2];

    rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .STARVE_MAX(SM)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .flush(flush),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .WR(WR), .WD(WD), .WE(WE)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    bit              m_busy [32];
    int              m_wait [3];
    bit              m_we;
    logic [AW-1:0]   m_wr;
    logic [XLEN-1:0] m_wd;

    function automatic int model_pick();
        int po[3];
        int no[3];
        po = '{0, 2, 1};   // promoted order: ALU, MDU, LSU
        no = '{1, 2, 0};   // normal order:   LSU, MDU, ALU
        for (int i = 0; i < 3; i++)
            if (req_v[po[i]] && m_wait[po[i]] == SM) return po[i];
        for (int i = 0; i < 3; i++)
            if (req_v[no[i]]) return no[i];
        return 3;
    endfunction

    task automatic model_clear();
        foreach (m_busy[i]) m_busy[i] = 0;
        foreach (m_wait[i]) m_wait[i] = 0;
        m_we = 0; m_wr = '0; m_wd = '0;
    endtask

    // Called just after a negedge with inputs set. Checks everything against the
    // model, crosses the posedge, advances the model, retires granted requests
    // and one-shot controls, and returns at the next negedge.
    task automatic cycle(output int gd);
        int g;
        bit iss_rdy;
        #1;
        g = model_pick();
        iss_rdy = (issue_rd == 0) || !m_busy[issue_rd];
        chk("alu_ready", alu_ready, g == 0);
        chk("lsu_ready", lsu_ready, g == 1);
        chk("mdu_ready", mdu_ready, g == 2);
        chk("issue_ready", issue_ready, iss_rdy);
        chk("rs1_busy", rs1_busy, m_busy[rs1]);
        chk("rs2_busy", rs2_busy, m_busy[rs2]);
        chk("WE", WE, m_we);
        chk("WR", WR, m_wr);
        chk("WD", WD, m_wd);
        gd = alu_ready ? 0 : lsu_ready ? 1 : mdu_ready ? 2 : 3;
        @(posedge CLK);
        if (flush) begin
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            if (m_we) m_busy[m_wr] = 0;
            if (issue_valid && iss_rdy && issue_rd != 0) m_busy[issue_rd] = 1;
        end
        for (int i = 0; i < 3; i++)
            m_wait[i] = (req_v[i] && g != i) ? ((m_wait[i] < SM) ? m_wait[i] + 1 : SM) : 0;
        if (g < 3 && req_rd[g] != 0) begin
            m_we = 1; m_wr = req_rd[g]; m_wd = req_wd[g];
        end else
            m_we = 0;
        #1;
        if (g < 3) req_v[g] = 0;
        issue_valid = 0;
        flush = 0;
        @(negedge CLK);
    endtask

    task automatic reset_check();
        @(negedge CLK);
        #3 RST_N = 0;
        #1;
        chk("rst_WE", WE, 0);
        chk("rst_WR", WR, 0);
        chk("rst_WD", WD, 0);
        for (int r = 0; r < 32; r++) begin
            rs1 = r[AW-1:0];
            #1 chk("rst_rs1_busy", rs1_busy, 0);
        end
        model_clear();
        foreach (req_v[i]) req_v[i] = 0;
        issue_valid = 0; flush = 0; rs1 = '0; rs2 = '0;
        @(negedge CLK);
        RST_N = 1;
    endtask

    task automatic drain();
        int gd;
        for (int n = 0; n < 12 && (req_v[0] || req_v[1] || req_v[2]); n++) cycle(gd);
        chk("drain_idle", {req_v[0], req_v[1], req_v[2]}, 0);
        cycle(gd);
    endtask

    initial begin
        int gd;
        int alu_cyc;
        issue_valid = 0; issue_rd = '0; flush = 0; rs1 = '0; rs2 = '0;
        foreach (req_v[i]) begin req_v[i] = 0; req_rd[i] = '0; req_wd[i] = '0; end
        model_clear();
        reset_check();

        // single write through the ALU
        issue_valid = 1; issue_rd = 5;
        cycle(gd);
        rs1 = 5; req_v[0] = 1; req_rd[0] = 5; req_wd[0] = 32'hDEADBEEF;
        #1 chk("t2_busy", rs1_busy, 1);
        chk("t2_alu_ready", alu_ready, 1);
        cycle(gd);
        #1 chk("t2_we", WE, 1);
        chk("t2_wr", WR, 5);
        chk("t2_wd", WD, 32'hDEADBEEF);
        chk("t2_busy_hold", rs1_busy, 1);
        cycle(gd);
        #1 chk("t2_busy_drop", rs1_busy, 0);
        cycle(gd);

        // three-way contention, fixed priority
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 1; req_rd[i] = AW'(10 + i); req_wd[i] = 32'h100 + i;
        end
        cycle(gd); chk("t3_first_lsu", gd, 1);
        cycle(gd); chk("t3_second_mdu", gd, 2);
        cycle(gd); chk("t3_third_alu", gd, 0);
        cycle(gd);

        // starvation: LSU re-requests every cycle
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 1; req_rd[i] = AW'(20 + i); req_wd[i] = 32'h200 + i;
        end
        alu_cyc = -1;
        for (int c = 0; c < 12 && alu_cyc < 0; c++) begin
            cycle(gd);
            if (gd == 0) alu_cyc = c;
            if (gd == 1) begin req_v[1] = 1; req_wd[1] = $urandom; end
        end
        chk("t3_alu_promoted_cycle", alu_cyc, SM);
        cycle(gd); chk("t3_mdu_promoted_next", gd, 2);
        req_v[1] = 0;
        drain();

        // x0 write and x0 issue
        req_v[1] = 1; req_rd[1] = 0; req_wd[1] = 32'h1234;
        issue_valid = 1; issue_rd = 0; rs1 = 0;
        #1 chk("t4_lsu_ready", lsu_ready, 1);
        chk("t4_issue_ready", issue_ready, 1);
        cycle(gd);
        #1 chk("t4_we", WE, 0);
        chk("t4_busy0", rs1_busy, 0);
        cycle(gd);

        // issue and commit to the same register on one edge
        req_v[1] = 1; req_rd[1] = 7; req_wd[1] = 32'h77; rs1 = 7;
        cycle(gd);
        issue_valid = 1; issue_rd = 7;
        #1 chk("t5_we", WE, 1);
        chk("t5_wr", WR, 7);
        chk("t5_issue_ready", issue_ready, 1);
        cycle(gd);
        #1 chk("t5_busy7_set", rs1_busy, 1);
        issue_valid = 1; issue_rd = 7;
        #1 chk("t5_waw_stall", issue_ready, 0);
        cycle(gd);

        // flush with a registered write in flight
        issue_valid = 1; issue_rd = 3; cycle(gd);
        issue_valid = 1; issue_rd = 9; cycle(gd);
        req_v[1] = 1; req_rd[1] = 3; req_wd[1] = 32'h33;
        cycle(gd);
        flush = 1; rs1 = 3; rs2 = 9; issue_valid = 1; issue_rd = 12;
        #1 chk("t6_busy3", rs1_busy, 1);
        chk("t6_busy9", rs2_busy, 1);
        chk("t6_we", WE, 1);
        chk("t6_wr", WR, 3);
        cycle(gd);
        #1 chk("t6_busy3_clr", rs1_busy, 0);
        chk("t6_busy9_clr", rs2_busy, 0);
        rs1 = 12;
        #1 chk("t6_issue_ignored", rs1_busy, 0);
        cycle(gd);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++)
                if (!req_v[i] && $urandom_range(2) == 0) begin
                    req_v[i] = 1;
                    req_rd[i] = AW'($urandom_range(7));
                    req_wd[i] = $urandom;
                end
            issue_valid = $urandom_range(1) == 1;
            issue_rd = AW'($urandom_range(7));
            rs1 = AW'($urandom_range(7));
            rs2 = AW'($urandom_range(7));
            flush = $urandom_range(19) == 0;
            cycle(gd);
        end

        reset_check();
        cycle(gd);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
